// File: rtl/pong_pkg.sv
// Shared types and helpers for the Pong game-flow controller.
// State encodings are fixed because the text overlay decodes them directly.
package pong_pkg;

   typedef enum logic [2:0] {
      ST_NEWGAME = 3'd0,
      ST_PLAY    = 3'd1,
      ST_PAUSED  = 3'd2,
      ST_NEWBALL = 3'd3,
      ST_OVER    = 3'd4
   } state_t;

   localparam logic [2:0] NO_WINNER = 3'd7;
   localparam int BCD_W   = 4;
   localparam int BALL_W  = 7;
   localparam int TIMER_W = 8;

   // Saturating decrement so the ball counter can never wrap below zero.
   function automatic logic [BALL_W-1:0] dec_sat(input logic [BALL_W-1:0] v);
      return (v == '0) ? '0 : v - 7'd1;
   endfunction

   function automatic logic [6:0] bcd_to_bin(input logic [BCD_W-1:0] tens,
                                             input logic [BCD_W-1:0] units);
      return 7'(tens) * 7'd10 + 7'(units);
   endfunction

endpackage

// File: rtl/pong_game_ctrl_bcd2_counter.sv
// Two-digit BCD score counter for one player, with a win-score detector
// that looks at the post-increment value so the FSM can react in the same cycle.
module bcd2_counter
   import pong_pkg::*;
#(
   parameter int WIN_SCORE = 11
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             inc,
   input  logic             clr,
   output logic [BCD_W-1:0] dig1,
   output logic [BCD_W-1:0] dig0,
   output logic             hit
);

   localparam logic [BCD_W-1:0] WIN_TENS  = BCD_W'(WIN_SCORE / 10);
   localparam logic [BCD_W-1:0] WIN_UNITS = BCD_W'(WIN_SCORE % 10);

   logic [BCD_W-1:0] nxt1;
   logic [BCD_W-1:0] nxt0;

   // 99 wraps to 00 even though a sane win score never lets us get there.
   always_comb begin
      nxt1 = dig1;
      nxt0 = dig0 + 4'd1;
      if (dig0 == 4'd9) begin
         nxt0 = '0;
         nxt1 = (dig1 == 4'd9) ? '0 : dig1 + 4'd1;
      end
   end

   assign hit = inc && (nxt1 == WIN_TENS) && (nxt0 == WIN_UNITS);

   always_ff @(posedge clk) begin
      if (!reset_n || clr) begin
         dig1 <= '0;
         dig0 <= '0;
      end else if (inc) begin
         dig1 <= nxt1;
         dig0 <= nxt0;
      end
   end

endmodule

// File: rtl/pong_game_ctrl.sv
// Game-flow controller: serve/pause/over sequencing, ball budget, frame-counted
// delays and winner reporting for the Pong graphics and text units.
module pong_game_ctrl
   import pong_pkg::*;
#(
   parameter int NUM_PLAYERS = 2,
   parameter int BALLS       = 7,
   parameter int WIN_SCORE   = 11,
   parameter int SERVE_TICKS = 120,
   parameter int OVER_TICKS  = 180
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     frame_tick,
   input  logic                     start,
   input  logic [NUM_PLAYERS-1:0]   pts,
   input  logic                     pause,
   output logic [2:0]               state,
   output logic                     gra_still,
   output logic [BALL_W-1:0]        balls_left,
   output logic [8*NUM_PLAYERS-1:0] score_bcd,
   output logic [2:0]               winner,
   output logic                     game_over
);

   localparam logic [BALL_W-1:0]  BALLS_INIT = BALL_W'(BALLS);
   localparam logic [TIMER_W-1:0] SERVE_LOAD = TIMER_W'(SERVE_TICKS);
   localparam logic [TIMER_W-1:0] OVER_LOAD  = TIMER_W'(OVER_TICKS);

   state_t               st_q;
   state_t               st_nxt;
   logic [TIMER_W-1:0]   timer_q;
   logic [TIMER_W-1:0]   timer_nxt;
   logic [BALL_W-1:0]    balls_nxt;
   logic [2:0]           winner_nxt;
   logic [2:0]           win_calc;
   logic                 start_q;
   logic                 start_ev;
   logic                 score_clr;
   logic [NUM_PLAYERS-1:0] inc;
   logic [NUM_PLAYERS-1:0] hits;
   logic [BCD_W-1:0]     dig1     [NUM_PLAYERS];
   logic [BCD_W-1:0]     dig0     [NUM_PLAYERS];
   logic [6:0]           next_val [NUM_PLAYERS];

   assign state    = st_q;
   assign start_ev = start & ~start_q;
   assign inc      = (st_q == ST_PLAY) ? pts : '0;
   // Clearing on the transition edge means NEWGAME shows 00 from its first cycle.
   assign score_clr = (st_nxt == ST_NEWGAME);

   for (genvar i = 0; i < NUM_PLAYERS; i++) begin : g_player
      bcd2_counter #(
         .WIN_SCORE(WIN_SCORE)
      ) u_cnt (
         .clk     (clk),
         .reset_n (reset_n),
         .inc     (inc[i]),
         .clr     (score_clr),
         .dig1    (dig1[i]),
         .dig0    (dig0[i]),
         .hit     (hits[i])
      );
      assign score_bcd[8*i +: 8] = {dig1[i], dig0[i]};
   end

   // Scores as they will be after this edge, so winner is valid on OVER entry.
   always_comb begin
      for (int i = 0; i < NUM_PLAYERS; i++) begin
         next_val[i] = bcd_to_bin(dig1[i], dig0[i]);
         if (inc[i]) begin
            next_val[i] = (next_val[i] == 7'd99) ? 7'd0 : next_val[i] + 7'd1;
         end
      end
   end

   always_comb begin
      logic [6:0] best;
      logic [2:0] best_idx;
      logic       tie;
      best     = '0;
      best_idx = '0;
      tie      = 1'b0;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
         if (i == 0 || next_val[i] > best) begin
            best     = next_val[i];
            best_idx = 3'(i);
            tie      = 1'b0;
         end else if (next_val[i] == best) begin
            tie = 1'b1;
         end
      end
      win_calc = tie ? NO_WINNER : best_idx;
   end

   always_comb begin
      st_nxt     = st_q;
      balls_nxt  = balls_left;
      winner_nxt = winner;
      timer_nxt  = timer_q;
      if (frame_tick && timer_q != '0) begin
         timer_nxt = timer_q - 8'd1;
      end
      case (st_q)
         ST_NEWGAME: begin
            balls_nxt  = BALLS_INIT;
            winner_nxt = NO_WINNER;
            if (start_ev) begin
               st_nxt    = ST_PLAY;
               balls_nxt = dec_sat(BALLS_INIT);
            end
         end
         ST_PLAY: begin
            // A point outranks a simultaneous pause request.
            if (|pts) begin
               if (|hits || balls_left == '0) begin
                  st_nxt     = ST_OVER;
                  timer_nxt  = OVER_LOAD;
                  winner_nxt = win_calc;
               end else begin
                  st_nxt    = ST_NEWBALL;
                  timer_nxt = SERVE_LOAD;
                  balls_nxt = dec_sat(balls_left);
               end
            end else if (pause) begin
               st_nxt = ST_PAUSED;
            end
         end
         ST_PAUSED: begin
            if (pause) begin
               st_nxt = ST_PLAY;
            end
         end
         ST_NEWBALL: begin
            if (timer_q == '0 && start_ev) begin
               st_nxt = ST_PLAY;
            end
         end
         ST_OVER: begin
            if (timer_q == '0) begin
               st_nxt     = ST_NEWGAME;
               balls_nxt  = BALLS_INIT;
               winner_nxt = NO_WINNER;
            end
         end
         default: begin
            st_nxt = ST_NEWGAME;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         st_q       <= ST_NEWGAME;
         timer_q    <= '0;
         balls_left <= BALLS_INIT;
         winner     <= NO_WINNER;
         game_over  <= 1'b0;
         gra_still  <= 1'b1;
         start_q    <= 1'b1;
      end else begin
         st_q       <= st_nxt;
         timer_q    <= timer_nxt;
         balls_left <= balls_nxt;
         winner     <= winner_nxt;
         game_over  <= (st_nxt == ST_OVER);
         gra_still  <= (st_nxt != ST_PLAY);
         start_q    <= start;
      end
   end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench: a vector table walks one full default game, hand sequences
// cover BCD carry, win-score exit and mid-game reset on a second instance.
module tb_pong_game_ctrl;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        frame_tick;
   logic        start_a, start_b;
   logic        pause_a, pause_b;
   logic [1:0]  pts_a;
   logic [2:0]  pts_b;

   logic [2:0]  a_state, b_state;
   logic        a_still, b_still;
   logic [6:0]  a_balls, b_balls;
   logic [15:0] a_score;
   logic [23:0] b_score;
   logic [2:0]  a_win, b_win;
   logic        a_over, b_over;

   int n_total = 0;
   int n_pass  = 0;
   logic [7:0] exp_q[$];

   typedef struct {
      string       name;
      int          ticks;
      logic        st;
      logic [1:0]  pts;
      logic        ps;
      logic [2:0]  e_state;
      logic [15:0] e_score;
      logic [6:0]  e_balls;
      logic        e_still;
      logic [2:0]  e_win;
      logic        e_over;
   } vec_t;

   vec_t vecs[$];

   // clock / reset
   always #5 clk = ~clk;

   pong_game_ctrl u_a (
      .clk        (clk),
      .reset_n    (reset_n),
      .frame_tick (frame_tick),
      .start      (start_a),
      .pts        (pts_a),
      .pause      (pause_a),
      .state      (a_state),
      .gra_still  (a_still),
      .balls_left (a_balls),
      .score_bcd  (a_score),
      .winner     (a_win),
      .game_over  (a_over)
   );

   pong_game_ctrl #(
      .NUM_PLAYERS (3),
      .BALLS       (12),
      .WIN_SCORE   (10),
      .SERVE_TICKS (2),
      .OVER_TICKS  (3)
   ) u_b (
      .clk        (clk),
      .reset_n    (reset_n),
      .frame_tick (frame_tick),
      .start      (start_b),
      .pts        (pts_b),
      .pause      (pause_b),
      .state      (b_state),
      .gra_still  (b_still),
      .balls_left (b_balls),
      .score_bcd  (b_score),
      .winner     (b_win),
      .game_over  (b_over)
   );

   function automatic vec_t mk(string n, int t, logic s, logic [1:0] p, logic ps,
                               logic [2:0] es, logic [15:0] sc, logic [6:0] b,
                               logic still, logic [2:0] w, logic ov);
      vec_t v;
      v.name = n; v.ticks = t; v.st = s; v.pts = p; v.ps = ps;
      v.e_state = es; v.e_score = sc; v.e_balls = b; v.e_still = still;
      v.e_win = w; v.e_over = ov;
      return v;
   endfunction

   function automatic logic [7:0] to_bcd(int n);
      return {4'(n / 10), 4'(n % 10)};
   endfunction

   // scoreboard
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic chk_a(input string n, input logic [2:0] es, input logic [15:0] sc,
                        input logic [6:0] b, input logic still, input logic [2:0] w,
                        input logic ov);
      chk($sformatf("%s.state", n), 32'(a_state), 32'(es));
      chk($sformatf("%s.score", n), 32'(a_score), 32'(sc));
      chk($sformatf("%s.balls", n), 32'(a_balls), 32'(b));
      chk($sformatf("%s.still", n), 32'(a_still), 32'(still));
      chk($sformatf("%s.winner", n), 32'(a_win), 32'(w));
      chk($sformatf("%s.over", n), 32'(a_over), 32'(ov));
   endtask

   // drivers (all called on a negedge)
   task automatic ticks(input int n);
      if (n > 0) begin
         frame_tick = 1'b1;
         repeat (n) @(negedge clk);
         frame_tick = 1'b0;
      end
   endtask

   task automatic apply_a(input vec_t v);
      ticks(v.ticks);
      start_a = v.st; pts_a = v.pts; pause_a = v.ps;
      @(negedge clk);
      start_a = 1'b0; pts_a = '0; pause_a = 1'b0;
      chk_a(v.name, v.e_state, v.e_score, v.e_balls, v.e_still, v.e_win, v.e_over);
   endtask

   task automatic pulse_b(input logic s, input logic [2:0] p);
      start_b = s; pts_b = p;
      @(negedge clk);
      start_b = 1'b0; pts_b = '0;
   endtask

   initial begin
      logic [7:0] e;
      reset_n = 1'b0; frame_tick = 1'b0;
      start_a = 1'b1; start_b = 1'b0;
      pause_a = 1'b0; pause_b = 1'b0;
      pts_a = '0; pts_b = '0;

      vecs.push_back(mk("start",        0, 1, 2'b00, 0, 3'd1, 16'h0000, 7'd6, 0, 3'd7, 0));
      vecs.push_back(mk("pt1",          0, 0, 2'b01, 0, 3'd3, 16'h0001, 7'd5, 1, 3'd7, 0));
      vecs.push_back(mk("early_start", 60, 1, 2'b00, 0, 3'd3, 16'h0001, 7'd5, 1, 3'd7, 0));
      vecs.push_back(mk("start_t119",  59, 1, 2'b00, 0, 3'd3, 16'h0001, 7'd5, 1, 3'd7, 0));
      vecs.push_back(mk("serve1",       1, 1, 2'b00, 0, 3'd1, 16'h0001, 7'd5, 0, 3'd7, 0));
      vecs.push_back(mk("pt2",          0, 0, 2'b01, 0, 3'd3, 16'h0002, 7'd4, 1, 3'd7, 0));
      vecs.push_back(mk("serve2",     120, 1, 2'b00, 0, 3'd1, 16'h0002, 7'd4, 0, 3'd7, 0));
      vecs.push_back(mk("pt3",          0, 0, 2'b01, 0, 3'd3, 16'h0003, 7'd3, 1, 3'd7, 0));
      vecs.push_back(mk("serve3",     120, 1, 2'b00, 0, 3'd1, 16'h0003, 7'd3, 0, 3'd7, 0));
      vecs.push_back(mk("pause",        0, 0, 2'b00, 1, 3'd2, 16'h0003, 7'd3, 1, 3'd7, 0));
      vecs.push_back(mk("pts_paused",   0, 0, 2'b11, 0, 3'd2, 16'h0003, 7'd3, 1, 3'd7, 0));
      vecs.push_back(mk("unpause",      0, 0, 2'b00, 1, 3'd1, 16'h0003, 7'd3, 0, 3'd7, 0));
      vecs.push_back(mk("pts_and_pause",0, 0, 2'b11, 1, 3'd3, 16'h0104, 7'd2, 1, 3'd7, 0));
      vecs.push_back(mk("serve4",     120, 1, 2'b00, 0, 3'd1, 16'h0104, 7'd2, 0, 3'd7, 0));
      vecs.push_back(mk("pt4",          0, 0, 2'b10, 0, 3'd3, 16'h0204, 7'd1, 1, 3'd7, 0));
      vecs.push_back(mk("serve5",     120, 1, 2'b00, 0, 3'd1, 16'h0204, 7'd1, 0, 3'd7, 0));
      vecs.push_back(mk("pt5",          0, 0, 2'b10, 0, 3'd3, 16'h0304, 7'd0, 1, 3'd7, 0));
      vecs.push_back(mk("serve6",     120, 1, 2'b00, 0, 3'd1, 16'h0304, 7'd0, 0, 3'd7, 0));
      vecs.push_back(mk("last_ball",    0, 0, 2'b10, 0, 3'd4, 16'h0404, 7'd0, 1, 3'd7, 1));
      vecs.push_back(mk("over_t179",  179, 0, 2'b00, 0, 3'd4, 16'h0404, 7'd0, 1, 3'd7, 1));
      vecs.push_back(mk("over_end",     1, 0, 2'b00, 0, 3'd0, 16'h0000, 7'd7, 1, 3'd7, 0));

      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      chk_a("reset", 3'd0, 16'h0000, 7'd7, 1'b1, 3'd7, 1'b0);

      // start held high across reset must not count as a press
      repeat (3) @(negedge clk);
      chk("hold_start.state", 32'(a_state), 32'd0);
      start_a = 1'b0;
      @(negedge clk);

      for (int i = 0; i < vecs.size(); i++) apply_a(vecs[i]);

      // instance B: BCD carry 09->10 and exit on win score with a single winner
      pulse_b(1'b1, 3'b000);
      chk("b_start.state", 32'(b_state), 32'd1);
      chk("b_start.balls", 32'(b_balls), 32'd11);
      for (int i = 1; i <= 9; i++) exp_q.push_back(to_bcd(i));
      for (int i = 1; i <= 9; i++) begin
         pulse_b(1'b0, 3'b010);
         e = exp_q.pop_front();
         chk($sformatf("b_pt%0d.score", i), 32'(b_score), 32'({8'h00, e, 8'h00}));
         chk($sformatf("b_pt%0d.state", i), 32'(b_state), 32'd3);
         chk($sformatf("b_pt%0d.balls", i), 32'(b_balls), 32'(11 - i));
         ticks(2);
         pulse_b(1'b1, 3'b000);
         chk($sformatf("b_serve%0d.state", i), 32'(b_state), 32'd1);
      end
      pulse_b(1'b0, 3'b011);
      chk("b_win.state",  32'(b_state), 32'd4);
      chk("b_win.score",  32'(b_score), 32'h001001);
      chk("b_win.winner", 32'(b_win),   32'd1);
      chk("b_win.over",   32'(b_over),  32'd1);
      chk("b_win.still",  32'(b_still), 32'd1);
      chk("b_win.balls",  32'(b_balls), 32'd2);
      ticks(2);
      @(negedge clk);
      chk("b_over_t2.state", 32'(b_state), 32'd4);
      ticks(1);
      @(negedge clk);
      chk("b_over_end.state",  32'(b_state), 32'd0);
      chk("b_over_end.score",  32'(b_score), 32'd0);
      chk("b_over_end.balls",  32'(b_balls), 32'd12);
      chk("b_over_end.winner", 32'(b_win),   32'd7);

      // reset in the middle of a serve delay on instance A
      apply_a(mk("r_start", 0, 1, 2'b00, 0, 3'd1, 16'h0000, 7'd6, 0, 3'd7, 0));
      apply_a(mk("r_pt",    0, 0, 2'b01, 0, 3'd3, 16'h0001, 7'd5, 1, 3'd7, 0));
      ticks(10);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      chk_a("mid_reset", 3'd0, 16'h0000, 7'd7, 1'b1, 3'd7, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/pong_game_ctrl.md
# pong_game_ctrl

Parametrised game-flow controller for the Pong display pipeline, sitting between the graphics engine, the VGA frame tick and the text overlay. It supports 2–4 players with BCD score counters, a configurable ball budget and win score, and frame-counted serve and game-over delays. Unlike the first-generation controller, it actually reaches a game-over state, on ball exhaustion or when a player reaches the win score, and it reports the winner. It drives `gra_still` to the graphics unit, and drives scores, balls left, state and winner to the text unit.

## Interface
- `NUM_PLAYERS`, 2 — number of players/score channels, legal range 2..4.
- `BALLS`, 7 — balls per game, 1..127.
- `WIN_SCORE`, 11 — score that ends the game, 1..99.
- `SERVE_TICKS`, 120 — frame ticks spent in NEWBALL before a serve is allowed (2 s at 60 Hz), 1..255.
- `OVER_TICKS`, 180 — frame ticks spent in OVER before returning to NEWGAME, 1..255.

- `clk` in 1 — 100 MHz system clock.
- `reset_n` in 1 — synchronous, active-low reset.
- `frame_tick` in 1 — one-cycle pulse per frame (x==0 && y==0).
- `start` in 1 — OR of player buttons; a level signal.
- `pts` in `NUM_PLAYERS` — one-cycle point pulses from the graphics unit; bit i means player i scored.
- `pause` in 1 — one-cycle toggle request.
- `state` out 3 — current state encoding.
- `gra_still` out 1 — 1 freezes the graphics.
- `balls_left` out 7 — remaining balls.
- `score_bcd` out `8*NUM_PLAYERS` — two BCD digits per player; player i occupies bits [8i+7:8i], with the tens digit high.
- `winner` out 3 — index of the winning player; the value 7 means none/tie.
- `game_over` out 1 — high while in OVER.

## Operation
- States: NEWGAME, PLAY, PAUSED, NEWBALL, OVER.
- All outputs are registered. Reset (`reset_n`=0 at a clk edge) forces:
  - state=NEWGAME
  - balls_left=BALLS
  - all scores 00
  - winner=7
  - game_over=0
  - gra_still=1
  - timer=0
  - the start edge detector cleared, with the previous-value register set to 1 so that a held button does not trigger a start
- Start event: `start` rising edge, i.e. registered previous value 0 and current value 1.
- NEWGAME:
  - balls_left held at BALLS, scores cleared, winner=7.
  - A start event moves to PLAY and decrements balls_left by 1 (the serve).
- PLAY:
  - gra_still=0.
  - If any `pts` bit is set, every asserted player's score increments by 1. Simultaneous points all count.
  - Then:
    - If any score has just reached WIN_SCORE, go to OVER.
    - Otherwise, if balls_left==0, go to OVER.
    - Otherwise go to NEWBALL, load the timer with SERVE_TICKS, and decrement balls_left.
  - A `pause` pulse with no points goes to PAUSED. If `pts` and `pause` arrive together, `pts` wins and `pause` is dropped.
- PAUSED: gra_still=1, and `pts` is ignored. A `pause` pulse returns to PLAY.
- NEWBALL: the timer decrements on each frame_tick. When timer==0 and a start event occurs, go to PLAY. A start event before expiry is ignored; it is not latched.
- OVER:
  - Entry loads the timer with OVER_TICKS.
  - winner = the index of the highest score. On a tie for the highest score, winner=7.
  - game_over=1.
  - At timer==0, go to NEWGAME.
- `pts` and `pause` are ignored outside the states listed above.
- BCD counter: units digit 9 with an increment gives units 0 and tens+1. 99 with an increment wraps to 00; this is unreachable when WIN_SCORE≤99, but must still be implemented.
- balls_left never underflows. A decrement at 0 is suppressed.

## Timing
- Single clock domain. State and outputs update on the clk edge after the qualifying input cycle, giving 1-cycle latency from `pts`, `pause` or start edge to the new state and scores.
- Score increment and state change occur in the same cycle.
- winner is valid on the first cycle that state==OVER.
- Timer: the load happens on the entering edge. The first decrement happens on the next frame_tick. Expiry is exactly N frame_ticks after entry.
- A frame_tick coinciding with the load cycle is not counted.
- Synchronous reset mid-game aborts within one cycle. No partial score is retained.

## Structure
- Package `pong_pkg`:
  - state enum with encodings NEWGAME=0, PLAY=1, PAUSED=2, NEWBALL=3, OVER=4
  - `NO_WINNER`=3'd7
  - BCD digit width constant
- Sub-module `bcd2_counter`, one instance per player via generate, with ports:
  - clk, reset_n
  - inc, clr
  - dig1, dig0
  - hit, a combinational comparison against WIN_SCORE
- The FSM, timer, ball counter, start edge detector and winner reduction live in the top level.

## Test plan
- Reset, then hold `start`=1 → stays in NEWGAME. Release `start`, then press again → PLAY with balls_left=BALLS-1=6.
- In PLAY, pulse pts=2'b01 three times, with each serve after SERVE_TICKS=120 frame ticks → score_bcd[7:0]=8'h03. A start event at tick 60 is ignored.
- In PLAY, assert pts=2'b11 together → both scores +1 and one ball consumed. With the scores at 9, the result is 8'h10 for both players.
- WIN_SCORE=3, player 1 scores 3 → OVER on the next cycle, winner=1, game_over=1. After 180 frame ticks → NEWGAME with scores 00.
- BALLS=2, with points split 1–1 → OVER on balls exhausted, winner=7. `pause` in PLAY freezes gra_still=1, and `pts` pulses while PAUSED leave the scores unchanged.
- Pulse `reset_n`=0 mid-NEWBALL → next cycle: NEWGAME, scores 00, balls_left=BALLS, timer 0.
